// File: rtl/axi4_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : axi4_arb_pkg                                            |
// | Brief    : Shared types and constants for the AXI4 memory-port     |
// |            arbiter (FSM states, burst owner, AXI response codes).  |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package axi4_arb_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WR_BURST = 2'd1,
      RD_BURST = 2'd2
   } arb_state_t;

   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } owner_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage
`default_nettype wire

// File: rtl/axi4_burst_range_chk.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : axi4_burst_range_chk                                    |
// | Brief    : Flags an INCR burst whose last word lies beyond the     |
// |            memory. Sum is formed one bit wider than the byte       |
// |            address so large bases with long bursts cannot wrap.   |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module axi4_burst_range_chk #(
   parameter int ADDR_WIDTH   = 16,
   parameter int MEMORY_DEPTH = 1024
) (
   input  logic [ADDR_WIDTH-3:0] base,
   input  logic [7:0]            len,
   output logic                  err
);

   localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH+1)'(MEMORY_DEPTH);
   localparam logic [ADDR_WIDTH:0] c_one   = (ADDR_WIDTH+1)'(1);

   logic [ADDR_WIDTH:0] w_end;

   assign w_end = (ADDR_WIDTH+1)'(base) + (ADDR_WIDTH+1)'(len) + c_one;
   assign err   = (w_end > c_depth);

endmodule
`default_nettype wire

// File: rtl/axi4_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : axi4_mem_port_arbiter                                   |
// | Brief    : Round-robin, whole-burst owner of a single-port word    |
// |            memory shared by the AXI4 write and read burst engines. |
// |            Generates per-beat word addresses, range-checks each    |
// |            burst and returns OKAY/SLVERR to the owning engine.     |
// | Options  : `define ARB_PERF_CNT_EN adds saturating burst and wait  |
// |            counters (wr_burst_cnt, rd_burst_cnt, wait_cnt).        |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module axi4_mem_port_arbiter
   import axi4_arb_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 16,
   parameter int MEMORY_DEPTH = 1024,
   parameter int MEM_AW       = $clog2(MEMORY_DEPTH)
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic                  wr_req,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [7:0]            wr_len,
   output logic                  wr_gnt,
   input  logic                  wr_beat,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_done,
   output logic [1:0]            wr_resp,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [7:0]            rd_len,
   output logic                  rd_gnt,
   input  logic                  rd_beat,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  rd_last,
   output logic [1:0]            rd_resp,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [MEM_AW-1:0]     mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [15:0]           wr_burst_cnt,
   output logic [15:0]           rd_burst_cnt,
   output logic [15:0]           wait_cnt
`endif
);

   localparam int c_bw = ADDR_WIDTH - 2;

   arb_state_t      r_state, w_state_nxt;
   owner_t          r_last_owner, w_last_owner_nxt;
   logic [c_bw-1:0] r_base, w_base_nxt;
   logic [7:0]      r_len, w_len_nxt;
   logic            r_err, w_err_nxt;
   // Beats accepted (write) or issued (read); only one burst is ever live
   logic [8:0]      r_cnt, w_cnt_nxt;
   logic            r_wr_done, w_wr_done_nxt;
   logic [1:0]      r_wr_resp, w_wr_resp_nxt;
   logic            r_rd_valid, w_rd_valid_nxt;
   logic            r_rd_last, w_rd_last_nxt;
   logic [1:0]      r_rd_resp, w_rd_resp_nxt;

   logic            w_pick_wr;
   logic [c_bw-1:0] w_sel_base;
   logic [7:0]      w_sel_len;
   logic            w_chk_err;
   logic [c_bw-1:0] w_idx;
   logic            w_unused;

   // Tie goes to the side that did not own the previous burst
   assign w_pick_wr  = wr_req && (!rd_req || (r_last_owner == READ));
   assign w_sel_base = w_pick_wr ? wr_addr[ADDR_WIDTH-1:2] : rd_addr[ADDR_WIDTH-1:2];
   assign w_sel_len  = w_pick_wr ? wr_len : rd_len;
   assign w_idx      = r_base + c_bw'(r_cnt);
   assign w_unused   = ^{wr_addr[1:0], rd_addr[1:0], w_idx};

   axi4_burst_range_chk #(
      .ADDR_WIDTH   (ADDR_WIDTH),
      .MEMORY_DEPTH (MEMORY_DEPTH)
   ) u_range_chk (
      .base (w_sel_base),
      .len  (w_sel_len),
      .err  (w_chk_err)
   );

   // State, burst context and registered response/handshake outputs
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state      <= IDLE;
         r_last_owner <= READ;
         r_base       <= '0;
         r_len        <= '0;
         r_err        <= 1'b0;
         r_cnt        <= '0;
         r_wr_done    <= 1'b0;
         r_wr_resp    <= RESP_OKAY;
         r_rd_valid   <= 1'b0;
         r_rd_last    <= 1'b0;
         r_rd_resp    <= RESP_OKAY;
      end else begin
         r_state      <= w_state_nxt;
         r_last_owner <= w_last_owner_nxt;
         r_base       <= w_base_nxt;
         r_len        <= w_len_nxt;
         r_err        <= w_err_nxt;
         r_cnt        <= w_cnt_nxt;
         r_wr_done    <= w_wr_done_nxt;
         r_wr_resp    <= w_wr_resp_nxt;
         r_rd_valid   <= w_rd_valid_nxt;
         r_rd_last    <= w_rd_last_nxt;
         r_rd_resp    <= w_rd_resp_nxt;
      end
   end

   // Arbitration, beat sequencing and same-cycle memory strobes
   always_comb begin
      w_state_nxt      = r_state;
      w_last_owner_nxt = r_last_owner;
      w_base_nxt       = r_base;
      w_len_nxt        = r_len;
      w_err_nxt        = r_err;
      w_cnt_nxt        = r_cnt;
      w_wr_done_nxt    = 1'b0;
      w_wr_resp_nxt    = RESP_OKAY;
      w_rd_valid_nxt   = 1'b0;
      w_rd_last_nxt    = 1'b0;
      w_rd_resp_nxt    = RESP_OKAY;
      mem_en           = 1'b0;
      mem_we           = 1'b0;
      mem_addr         = '0;
      mem_wdata        = '0;
      case (r_state)
         IDLE: begin
            if (wr_req || rd_req) begin
               w_state_nxt = w_pick_wr ? WR_BURST : RD_BURST;
               w_base_nxt  = w_sel_base;
               w_len_nxt   = w_sel_len;
               w_err_nxt   = w_chk_err;
               w_cnt_nxt   = '0;
            end
         end
         WR_BURST: begin
            if (wr_beat) begin
               if (!r_err) begin
                  mem_en    = 1'b1;
                  mem_we    = 1'b1;
                  mem_addr  = w_idx[MEM_AW-1:0];
                  mem_wdata = wr_data;
               end
               w_cnt_nxt = r_cnt + 9'd1;
               if (r_cnt == {1'b0, r_len}) begin
                  w_state_nxt      = IDLE;
                  w_last_owner_nxt = WRITE;
                  w_wr_done_nxt    = 1'b1;
                  w_wr_resp_nxt    = r_err ? RESP_SLVERR : RESP_OKAY;
               end
            end
         end
         RD_BURST: begin
            if (r_rd_last) begin
               w_state_nxt      = IDLE;
               w_last_owner_nxt = READ;
            end else if (rd_beat && (r_cnt <= {1'b0, r_len})) begin
               if (!r_err) begin
                  mem_en   = 1'b1;
                  mem_addr = w_idx[MEM_AW-1:0];
               end
               w_cnt_nxt      = r_cnt + 9'd1;
               w_rd_valid_nxt = 1'b1;
               w_rd_last_nxt  = (r_cnt == {1'b0, r_len});
               w_rd_resp_nxt  = r_err ? RESP_SLVERR : RESP_OKAY;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      // An aborting reset must not touch the memory
      if (ARESET) begin
         mem_en    = 1'b0;
         mem_we    = 1'b0;
         mem_addr  = '0;
         mem_wdata = '0;
      end
   end

   assign wr_gnt   = (r_state == WR_BURST);
   assign rd_gnt   = (r_state == RD_BURST);
   assign wr_done  = r_wr_done;
   assign wr_resp  = r_wr_resp;
   assign rd_valid = r_rd_valid;
   assign rd_last  = r_rd_last;
   assign rd_resp  = r_rd_resp;
   assign rd_data  = (r_rd_valid && !r_err) ? mem_rdata : '0;

`ifdef ARB_PERF_CNT_EN
   logic [15:0] r_wr_burst_cnt, r_rd_burst_cnt, r_wait_cnt;

   // Saturating counts of completed bursts and of request-without-grant cycles
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_wr_burst_cnt <= '0;
         r_rd_burst_cnt <= '0;
         r_wait_cnt     <= '0;
      end else begin
         if (r_wr_done && (r_wr_burst_cnt != 16'hFFFF))
            r_wr_burst_cnt <= r_wr_burst_cnt + 16'd1;
         if (r_rd_valid && r_rd_last && (r_rd_burst_cnt != 16'hFFFF))
            r_rd_burst_cnt <= r_rd_burst_cnt + 16'd1;
         if (((wr_req && !wr_gnt) || (rd_req && !rd_gnt)) && (r_wait_cnt != 16'hFFFF))
            r_wait_cnt <= r_wait_cnt + 16'd1;
      end
   end

   assign wr_burst_cnt = r_wr_burst_cnt;
   assign rd_burst_cnt = r_rd_burst_cnt;
   assign wait_cnt     = r_wait_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi4_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_axi4_mem_port_arbiter                                |
// | Brief    : Self-checking bench: directed vector table, hand-built  |
// |            multi-cycle sequences and randomized bursts against a   |
// |            behavioural memory/burst model.                         |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_axi4_mem_port_arbiter;

   localparam int DW    = 32;
   localparam int AW    = 16;
   localparam int DEPTH = 1024;
   localparam int MAW   = 10;

   logic          ACLK = 1'b0;
   logic          ARESET;
   logic          wr_req, wr_beat, rd_req, rd_beat;
   logic [AW-1:0] wr_addr, rd_addr;
   logic [7:0]    wr_len, rd_len;
   logic [DW-1:0] wr_data;
   logic          wr_gnt, wr_done, rd_gnt, rd_valid, rd_last;
   logic [1:0]    wr_resp, rd_resp;
   logic [DW-1:0] rd_data, mem_wdata, mem_rdata;
   logic          mem_en, mem_we;
   logic [MAW-1:0] mem_addr;

   logic [DW-1:0] env_mem [0:DEPTH-1];   // memory as actually written by the DUT
   logic [DW-1:0] ref_mem [0:DEPTH-1];   // memory as the spec says it should be

   int checks = 0;
   int errors = 0;

   axi4_mem_port_arbiter #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEMORY_DEPTH(DEPTH), .MEM_AW(MAW)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_gnt(wr_gnt),
      .wr_beat(wr_beat), .wr_data(wr_data), .wr_done(wr_done), .wr_resp(wr_resp),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_gnt(rd_gnt),
      .rd_beat(rd_beat), .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
      .rd_resp(rd_resp), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 ACLK = ~ACLK;

   // Single-port synchronous memory with one-cycle read latency
   always @(posedge ACLK) begin
      if (mem_en && mem_we) env_mem[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= env_mem[mem_addr];
   end

   initial begin
      #900000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, " wr_gnt"}, wr_gnt, 0);     chk({tag, " rd_gnt"}, rd_gnt, 0);
      chk({tag, " wr_done"}, wr_done, 0);   chk({tag, " wr_resp"}, wr_resp, 0);
      chk({tag, " rd_valid"}, rd_valid, 0); chk({tag, " rd_last"}, rd_last, 0);
      chk({tag, " rd_resp"}, rd_resp, 0);   chk({tag, " rd_data"}, rd_data, 0);
      chk({tag, " mem_en"}, mem_en, 0);     chk({tag, " mem_we"}, mem_we, 0);
      chk({tag, " mem_addr"}, mem_addr, 0); chk({tag, " mem_wdata"}, mem_wdata, 0);
   endtask

   // Full write burst from an idle arbiter; gaps inserts random idle beats
   task automatic do_write(input logic [AW-1:0] addr, input logic [7:0] len,
                           input bit gaps, output logic [1:0] resp);
      int  base = int'(addr) / 4;
      bit  err  = (base + int'(len) + 1) > DEPTH;
      int  beat = 0;
      int  n    = 0;
      @(negedge ACLK);
      wr_req = 1'b1; wr_addr = addr; wr_len = len; wr_beat = 1'b0;
      #1 chk("wr gnt before entry", wr_gnt, 0);
      while (beat <= int'(len) && n < 2000) begin
         @(negedge ACLK);
         wr_beat = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         wr_data = $urandom;
         #1;
         chk("wr gnt held", wr_gnt, 1);
         chk("wr rd_gnt low", rd_gnt, 0);
         chk("wr done early", wr_done, 0);
         if (wr_beat) begin
            chk("wr mem_en", mem_en, !err);
            if (!err) begin
               chk("wr mem_we", mem_we, 1);
               chk("wr mem_addr", mem_addr, base + beat);
               chk("wr mem_wdata", mem_wdata, wr_data);
               ref_mem[base + beat] = wr_data;
            end
            beat++;
         end else begin
            chk("wr gap mem_en", mem_en, 0);
         end
         n++;
      end
      if (beat <= int'(len)) chk("wr burst timeout", 0, 1);
      @(negedge ACLK);
      wr_beat = 1'b0;
      #1;
      chk("wr done pulse", wr_done, 1);
      chk("wr gnt released", wr_gnt, 0);
      chk("wr resp", wr_resp, err ? 2'b10 : 2'b00);
      resp   = wr_resp;
      wr_req = 1'b0;
   endtask

   // Full read burst; mode 0 = rd_beat always, 1 = toggling, 2 = random
   task automatic do_read(input logic [AW-1:0] addr, input logic [7:0] len,
                          input int mode, output logic [1:0] resp);
      int            base   = int'(addr) / 4;
      bit            err    = (base + int'(len) + 1) > DEPTH;
      int            issued = 0;
      int            got    = 0;
      int            n      = 0;
      bit            done   = 0;
      bit            pend   = 0;
      bit            pend_last = 0;
      bit            issue;
      logic [DW-1:0] pend_data = '0;
      resp = 2'b00;
      @(negedge ACLK);
      rd_req = 1'b1; rd_addr = addr; rd_len = len; rd_beat = 1'b0;
      #1 chk("rd gnt before entry", rd_gnt, 0);
      while (!done && n < 3000) begin
         @(negedge ACLK);
         rd_beat = (mode == 0) ? 1'b1 : (mode == 1) ? ((n % 2) == 0) : 1'($urandom_range(0, 1));
         #1;
         chk("rd gnt held", rd_gnt, 1);
         chk("rd wr_gnt low", wr_gnt, 0);
         chk("rd valid", rd_valid, pend);
         chk("rd last", rd_last, pend && pend_last);
         if (pend) begin
            chk("rd data", rd_data, pend_data);
            chk("rd resp", rd_resp, err ? 2'b10 : 2'b00);
            resp = rd_resp;
            got++;
            if (pend_last) done = 1;
         end
         issue = rd_beat && (issued <= int'(len));
         chk("rd mem_en", mem_en, issue && !err);
         if (issue && !err) begin
            chk("rd mem_we", mem_we, 0);
            chk("rd mem_addr", mem_addr, base + issued);
         end
         pend      = issue;
         pend_last = (issued == int'(len));
         pend_data = err ? '0 : ((base + issued) < DEPTH ? ref_mem[base + issued] : '0);
         if (issue) issued++;
         n++;
      end
      rd_beat = 1'b0; rd_req = 1'b0;
      if (!done) chk("rd burst timeout", 0, 1);
      chk("rd beat count", got, int'(len) + 1);
      @(negedge ACLK);
      #1;
      chk("rd gnt released", rd_gnt, 0);
      chk("rd valid after last", rd_valid, 0);
   endtask

   typedef struct {
      bit            is_wr;
      logic [AW-1:0] addr;
      logic [7:0]    len;
      logic [1:0]    exp_resp;
   } vec_t;

   vec_t vecs [11];

   initial begin
      logic [1:0]    resp;
      logic [DW-1:0] d;

      vecs[0]  = '{1'b1, 16'h0010, 8'd3,   2'b00};  // words 4..7
      vecs[1]  = '{1'b0, 16'h0010, 8'd3,   2'b00};  // read them back
      vecs[2]  = '{1'b0, 16'h0FF8, 8'd3,   2'b10};  // runs past the end
      vecs[3]  = '{1'b1, 16'h0FF8, 8'd3,   2'b10};  // dropped write
      vecs[4]  = '{1'b0, 16'h0FF8, 8'd1,   2'b00};  // exactly fits; unchanged data
      vecs[5]  = '{1'b1, 16'h0FFC, 8'd0,   2'b00};  // last word
      vecs[6]  = '{1'b1, 16'h0FFC, 8'd1,   2'b10};  // one past last word
      vecs[7]  = '{1'b0, 16'h1000, 8'd0,   2'b10};  // first word outside
      vecs[8]  = '{1'b1, 16'hFFFC, 8'd255, 2'b10};  // no wrap in the check
      vecs[9]  = '{1'b0, 16'h0000, 8'd255, 2'b00};
      vecs[10] = '{1'b0, 16'h0013, 8'd0,   2'b00};  // byte offset ignored

      ARESET = 1'b1;
      wr_req = 1'b0; wr_addr = '0; wr_len = '0; wr_beat = 1'b0; wr_data = '0;
      rd_req = 1'b0; rd_addr = '0; rd_len = '0; rd_beat = 1'b0;
      repeat (3) @(negedge ACLK);
      #1 check_idle("reset");
      @(negedge ACLK);
      ARESET = 1'b0;

      // Fill the whole memory so every later read has known contents
      for (int b = 0; b < 4; b++) begin
         do_write(AW'(b * 1024), 8'd255, 1'b0, resp);
         chk("preload resp", resp, 2'b00);
      end

      for (int i = 0; i < 11; i++) begin
         if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].len, 1'b0, resp);
         else               do_read(vecs[i].addr, vecs[i].len, 0, resp);
         chk($sformatf("vec%0d resp", i), resp, vecs[i].exp_resp);
      end

      // 8-beat read with rd_beat stalling every other cycle
      do_read(16'h0100, 8'd7, 1, resp);
      chk("toggle read resp", resp, 2'b00);

      // Reset two beats into a four-beat write
      @(negedge ACLK);
      wr_req = 1'b1; wr_addr = 16'h0040; wr_len = 8'd3;
      for (int k = 0; k < 2; k++) begin
         @(negedge ACLK);
         d = $urandom; wr_beat = 1'b1; wr_data = d;
         #1 chk("abort pre beat mem_en", mem_en, 1);
         ref_mem[16 + k] = d;
      end
      @(negedge ACLK);
      ARESET = 1'b1; wr_data = $urandom;
      #1 chk("abort reset cycle mem_en", mem_en, 0);
      @(negedge ACLK);
      ARESET = 1'b0; wr_beat = 1'b0; wr_req = 1'b0;
      #1 check_idle("after abort");
      @(negedge ACLK);
      #1 chk("no late wr_done", wr_done, 0);
      do_read(16'h0040, 8'd3, 0, resp);
      do_write(16'h0040, 8'd3, 1'b0, resp);
      chk("post abort write resp", resp, 2'b00);
      do_read(16'h0040, 8'd3, 0, resp);

      // Simultaneous requests out of reset: write first, then alternate
      @(negedge ACLK); ARESET = 1'b1;
      @(negedge ACLK); ARESET = 1'b0;
      wr_req = 1'b1; wr_addr = 16'h0080; wr_len = 8'd0;
      rd_req = 1'b1; rd_addr = 16'h0080; rd_len = 8'd0;
      @(negedge ACLK);
      d = $urandom; wr_beat = 1'b1; wr_data = d;
      #1;
      chk("tie1 wr_gnt", wr_gnt, 1);
      chk("tie1 rd_gnt", rd_gnt, 0);
      chk("tie1 mem_addr", mem_addr, 32);
      ref_mem[32] = d;
      @(negedge ACLK);
      wr_beat = 1'b0;
      #1;
      chk("tie1 wr_done", wr_done, 1);
      chk("tie1 rd_gnt during done", rd_gnt, 0);
      wr_req = 1'b0;
      @(negedge ACLK);
      rd_beat = 1'b1;
      #1;
      chk("tie1 rd_gnt", rd_gnt, 1);
      chk("tie1 rd mem_en", mem_en, 1);
      @(negedge ACLK);
      rd_beat = 1'b0; wr_req = 1'b1;
      #1;
      chk("tie1 rd_last", rd_last, 1);
      chk("tie1 rd_data", rd_data, ref_mem[32]);
      @(negedge ACLK);
      #1;
      chk("tie2 idle wr_gnt", wr_gnt, 0);
      chk("tie2 idle rd_gnt", rd_gnt, 0);
      @(negedge ACLK);
      d = $urandom; wr_beat = 1'b1; wr_data = d;
      #1;
      chk("tie2 wr_gnt", wr_gnt, 1);
      chk("tie2 rd_gnt", rd_gnt, 0);
      ref_mem[32] = d;
      @(negedge ACLK);
      wr_beat = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
      #1 chk("tie2 wr_done", wr_done, 1);

      // Randomized bursts against the model, including out-of-range ones
      for (int r = 0; r < 40; r++) begin
         int         rb  = $urandom_range(0, DEPTH + 8);
         logic [7:0] rl  = 8'($urandom_range(0, 15));
         logic [AW-1:0] ra = AW'(rb * 4 + $urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) do_write(ra, rl, 1'b1, resp);
         else                           do_read(ra, rl, 2, resp);
      end
      do_read(16'h0000, 8'd255, 0, resp);
      do_read(16'h0400, 8'd255, 0, resp);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
